// File: rtl/status_flag_unit.sv
// NZCV status register with in-flight flag-writer tracking, forwarding to the
// ID-stage condition check, and a stall signal when forwarding is disabled.
module status_flag_unit #(
  parameter int FLAG_STAGE = 1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_cond,
  input  logic       id_s,
  input  logic       id_issue,
  input  logic       flush,
  input  logic [3:0] exe_status,
  output logic [3:0] status,
  output logic [3:0] status_cond,
  output logic       flag_hazard,
  output logic [7:0] update_count
);

  localparam bit TWO_STAGE = (FLAG_STAGE == 2);

  logic       v_exe_q, v_exe_d;
  logic       v_mem_q, v_mem_d;
  logic [3:0] mem_status_q, mem_status_d;
  logic [3:0] status_q, status_d;
  logic [7:0] count_q, count_d;

  logic       commit;
  logic [3:0] commit_flags;
  logic       needs_flags;

  // In the one-stage build the MEM tracker is tied off so it never forwards.
  always_comb begin
    v_exe_d      = id_issue & id_s & ~flush;
    v_mem_d      = 1'b0;
    mem_status_d = 4'b0000;
    if (TWO_STAGE) begin
      v_mem_d      = v_exe_q;
      mem_status_d = exe_status;
    end
  end

  always_comb begin
    commit       = v_exe_q;
    commit_flags = exe_status;
    if (TWO_STAGE) begin
      commit       = v_mem_q;
      commit_flags = mem_status_q;
    end
  end

  always_comb begin
    status_d = status_q;
    count_d  = count_q;
    if (commit) begin
      status_d = commit_flags;
      count_d  = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_exe_q      <= 1'b0;
      v_mem_q      <= 1'b0;
      mem_status_q <= 4'b0000;
      status_q     <= 4'b0000;
      count_q      <= 8'd0;
    end else begin
      v_exe_q      <= v_exe_d;
      v_mem_q      <= v_mem_d;
      mem_status_q <= mem_status_d;
      status_q     <= status_d;
      count_q      <= count_d;
    end
  end

  // cond 1110 (AL) is the only encoding that ignores the flags.
  assign needs_flags = (id_cond != 4'b1110);

  // Youngest writer wins: EXE before MEM before the architectural register.
  always_comb begin
    status_cond = status_q;
    if (BYPASS) begin
      if (v_exe_q) begin
        status_cond = exe_status;
      end else if (v_mem_q) begin
        status_cond = mem_status_q;
      end
    end
  end

  assign flag_hazard  = (BYPASS == 1'b0) & needs_flags & (v_exe_q | v_mem_q);
  assign status       = status_q;
  assign update_count = count_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit: four instances cover every
// FLAG_STAGE/BYPASS combination, all driven by the same stimulus.
module tb_status_flag_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_cond;
  logic       id_s;
  logic       id_issue;
  logic       flush;
  logic [3:0] exe_status;

  logic [3:0] st11, sc11, st12, sc12, st21, sc21, st20, sc20;
  logic       hz11, hz12, hz21, hz20;
  logic [7:0] uc11, uc12, uc21, uc20;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  status_flag_unit #(.FLAG_STAGE(1), .BYPASS(1'b1)) u11 (
    .clk(clk), .rst(rst), .id_cond(id_cond), .id_s(id_s), .id_issue(id_issue),
    .flush(flush), .exe_status(exe_status), .status(st11), .status_cond(sc11),
    .flag_hazard(hz11), .update_count(uc11));
  status_flag_unit #(.FLAG_STAGE(1), .BYPASS(1'b0)) u12 (
    .clk(clk), .rst(rst), .id_cond(id_cond), .id_s(id_s), .id_issue(id_issue),
    .flush(flush), .exe_status(exe_status), .status(st12), .status_cond(sc12),
    .flag_hazard(hz12), .update_count(uc12));
  status_flag_unit #(.FLAG_STAGE(2), .BYPASS(1'b1)) u21 (
    .clk(clk), .rst(rst), .id_cond(id_cond), .id_s(id_s), .id_issue(id_issue),
    .flush(flush), .exe_status(exe_status), .status(st21), .status_cond(sc21),
    .flag_hazard(hz21), .update_count(uc21));
  status_flag_unit #(.FLAG_STAGE(2), .BYPASS(1'b0)) u20 (
    .clk(clk), .rst(rst), .id_cond(id_cond), .id_s(id_s), .id_issue(id_issue),
    .flush(flush), .exe_status(exe_status), .status(st20), .status_cond(sc20),
    .flag_hazard(hz20), .update_count(uc20));

  // Advance one rising edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic all_quiet(input string tag);
    chk({tag, "_st11"}, st11, 0); chk({tag, "_st21"}, st21, 0);
    chk({tag, "_uc11"}, uc11, 0); chk({tag, "_uc20"}, uc20, 0);
    chk({tag, "_hz12"}, hz12, 0); chk({tag, "_hz20"}, hz20, 0);
  endtask

  initial begin
    rst = 1'b0; id_cond = 4'h0; id_s = 1'b1; id_issue = 1'b1;
    flush = 1'b0; exe_status = 4'hF;

    // Reset held two edges with an active writer and all-ones flags.
    tick();
    all_quiet("rst_e1");
    tick();
    all_quiet("rst_e2");
    rst = 1'b1; id_issue = 1'b0; id_s = 1'b0; exe_status = 4'h0;
    #1;
    all_quiet("rst_rel");
    chk("rst_sc21", sc21, 0);
    tick();
    all_quiet("rst_rel_e");

    // Forwarding: writer issues, flags appear in EXE next cycle.
    id_issue = 1'b1; id_s = 1'b1; id_cond = 4'b0000;
    tick();
    id_issue = 1'b0; id_s = 1'b0; exe_status = 4'b0100;
    #1;
    chk("fwd_sc11", sc11, 4'b0100);
    chk("fwd_sc21", sc21, 4'b0100);
    chk("fwd_sc12_nobyp", sc12, 4'b0000);
    chk("fwd_hz12", hz12, 1);
    chk("fwd_hz20", hz20, 1);
    chk("fwd_hz11", hz11, 0);
    tick();
    chk("fwd_st11", st11, 4'b0100);
    chk("fwd_uc11", uc11, 1);
    chk("fwd_st21_pending", st21, 4'b0000);
    chk("fwd_sc21_mem", sc21, 4'b0100);
    chk("fwd_hz12_clear", hz12, 0);
    chk("fwd_hz20_mem", hz20, 1);
    exe_status = 4'b0000;
    tick();
    chk("fwd_st21", st21, 4'b0100);
    chk("fwd_uc21", uc21, 1);
    chk("fwd_hz20_clear", hz20, 0);

    // Stall with FLAG_STAGE=2, BYPASS=0 while MI is held in ID.
    id_issue = 1'b1; id_s = 1'b1; id_cond = 4'b0100;
    tick();
    id_issue = 1'b0; id_s = 1'b0; exe_status = 4'b1000;
    #1;
    chk("stall_hz20_c1", hz20, 1);
    chk("stall_hz12_c1", hz12, 1);
    tick();
    chk("stall_hz20_c2", hz20, 1);
    chk("stall_hz12_c2", hz12, 0);
    chk("stall_st20_hold", st20, 4'b0100);
    tick();
    chk("stall_hz20_c3", hz20, 0);
    chk("stall_st20", st20, 4'b1000);
    chk("stall_uc20", uc20, 2);

    // AL condition never stalls, even with a writer in flight.
    id_issue = 1'b1; id_s = 1'b1; id_cond = 4'b1110;
    tick();
    id_issue = 1'b0; id_s = 1'b0;
    #1;
    chk("al_hz20_exe", hz20, 0);
    chk("al_hz12_exe", hz12, 0);
    tick();
    chk("al_hz20_mem", hz20, 0);
    tick();

    // Back-to-back writers A then B in FLAG_STAGE=2 with forwarding.
    id_cond = 4'b0000; id_issue = 1'b1; id_s = 1'b1;
    tick();
    exe_status = 4'b0010;
    #1;
    chk("b2b_sc21_a", sc21, 4'b0010);
    tick();
    id_issue = 1'b0; id_s = 1'b0; exe_status = 4'b0001;
    #1;
    chk("b2b_sc21_b", sc21, 4'b0001);
    tick();
    chk("b2b_st21_a", st21, 4'b0010);
    chk("b2b_sc21_bmem", sc21, 4'b0001);
    chk("b2b_uc21_a", uc21, 4);
    tick();
    chk("b2b_st21_b", st21, 4'b0001);
    chk("b2b_uc21_b", uc21, 5);

    // Flush wins over issue: nothing enters EXE and nothing commits.
    id_issue = 1'b1; id_s = 1'b1; flush = 1'b1; exe_status = 4'hF;
    tick();
    id_issue = 1'b0; id_s = 1'b0; flush = 1'b0;
    #1;
    chk("flush_hz12", hz12, 0);
    chk("flush_sc11", sc11, 4'b0001);
    tick();
    chk("flush_st11", st11, 4'b0001);
    chk("flush_uc11", uc11, 5);
    tick();
    chk("flush_st21", st21, 4'b0001);
    chk("flush_uc21", uc21, 5);

    // Count wrap: fresh reset, then a continuous run of 256 writers.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("wrap_rst_uc11", uc11, 0);
    id_issue = 1'b1; id_s = 1'b1; exe_status = 4'b1010;
    repeat (255) tick();
    chk("wrap_uc11_254", uc11, 254);
    tick();
    chk("wrap_uc11_255", uc11, 255);
    id_issue = 1'b0; id_s = 1'b0;
    tick();
    chk("wrap_uc11_0", uc11, 0);
    chk("wrap_uc21_255", uc21, 255);
    chk("wrap_st11", st11, 4'b1010);
    tick();
    chk("wrap_uc21_0", uc21, 0);
    chk("wrap_st21", st21, 4'b1010);

    // Reset while a writer sits in MEM discards it.
    id_issue = 1'b1; id_s = 1'b1; exe_status = 4'b0110;
    tick();
    id_issue = 1'b0; id_s = 1'b0;
    tick();
    chk("mid_st11_commit", st11, 4'b0110);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_st21", st21, 0);
    chk("mid_uc21", uc21, 0);
    tick();
    chk("mid_st21_after", st21, 0);
    chk("mid_uc21_after", uc21, 0);
    chk("mid_hz20", hz20, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/status_flag_unit.md
# status_flag_unit

Holds the architectural NZCV status register and supplies the flag value that the ID-stage condition check evaluates against the instruction's cond field. It tracks flag-setting instructions in flight between ID and commit, and forwards their ALU flags to ID so conditional instructions see the newest value. If forwarding is disabled, it raises a stall instead. It sits between the EXE-stage ALU, which produces the flags, and the ID-stage condition check, which consumes them.

## Interface
- FLAG_STAGE, 1: stage whose end commits flags; 1 = end of EXE, 2 = end of MEM (ALU flags pipelined one stage internally).
- BYPASS, 1: 1 = forward in-flight flags to ID; 0 = stall ID on a pending flag writer.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- id_cond  in  4  cond field of the instruction in ID.
- id_s  in  1  instruction in ID sets flags (S bit).
- id_issue  in  1  instruction in ID advances into EXE this cycle.
- flush  in  1  taken-branch flush; kills the instruction in ID; overrides id_issue.
- exe_status  in  4  ALU flags {N,Z,C,V} of the instruction in EXE.
- status  out  4  architectural register {N,Z,C,V}.
- status_cond  out  4  flags presented to the condition check (combinational).
- flag_hazard  out  1  ID must freeze; the conditional instruction cannot read correct flags yet.
- update_count  out  8  number of flag commits, wraps.

## Operation
- Tracker bits:
  - v_exe: a flag writer is in EXE.
  - v_mem: a flag writer is in MEM. Exists only when FLAG_STAGE=2; otherwise constant 0.
  - mem_status[3:0]: flags of the writer in MEM.
- Each cycle, v_exe <= id_issue & id_s & ~flush.
- FLAG_STAGE=2 only: v_mem <= v_exe and mem_status <= exe_status.
- Commit:
  - FLAG_STAGE=1: when v_exe, status <= exe_status.
  - FLAG_STAGE=2: when v_mem, status <= mem_status.
  - Each commit increments update_count mod 256.
- needs_flags = (id_cond != 4'b1110). cond 4'b1111 counts as needing flags.
- status_cond with BYPASS=1 uses this priority:
  - v_exe: exe_status;
  - else v_mem: mem_status;
  - else status.
- status_cond with BYPASS=0 is always status.
- flag_hazard = ~BYPASS & needs_flags & (v_exe | v_mem). With BYPASS=1, flag_hazard is constantly 0.
- Upstream holds ID and deasserts id_issue while flag_hazard=1. This block does not gate id_issue itself.
- Non-flag-setting instructions do not disturb the tracker. Bubbles (id_issue=0) shift through as invalid.
- Flush applies only to the ID instruction. Writers already in EXE/MEM still commit.

## Timing
- Reset (rst=0 at a rising edge) sets:
  - status=0, update_count=0, v_exe=0, v_mem=0, mem_status=0.
  - Consequently flag_hazard=0 and status_cond=0 from the next cycle on.
- Reset mid-operation discards all in-flight writers with no commit.
- Commit latency from the cycle id_issue&id_s is sampled:
  - FLAG_STAGE=1: status changes after edge 2.
  - FLAG_STAGE=2: status changes after edge 3.
- Forwarding is visible the cycle after issue (same cycle the writer is in EXE).
- Back-to-back writers: the younger one wins in status_cond. In FLAG_STAGE=2 the older still commits first, then the younger one cycle later.
- Hazard duration with BYPASS=0 after the last writer issues:
  - FLAG_STAGE=1: 1 cycle.
  - FLAG_STAGE=2: 2 cycles.
- flush and id_issue asserted together: no writer enters; no commit results.
- update_count wrap: 255 -> 0 on the next commit, no flag output.

## Test plan
- Reset: hold rst=0 two cycles with exe_status=4'hF, id_issue=id_s=1; release. Required: status=0, update_count=0, flag_hazard=0 throughout reset and the first cycle after release.
- Forward, FLAG_STAGE=1, BYPASS=1:
  - Stimulus: issue S instruction, next cycle exe_status=4'b0100, id_cond=4'b0000 (EQ).
  - Required: status_cond=4'b0100 that cycle; status=4'b0100 after the edge; update_count=1.
- Stall, FLAG_STAGE=2, BYPASS=0:
  - Stimulus: issue S instruction (exe_status=4'b1000), then hold id_cond=4'b0100 (MI).
  - Required: flag_hazard=1 for exactly 2 cycles, then status=4'b1000 and flag_hazard=0.
  - With id_cond=4'b1110: flag_hazard stays 0.
- Back-to-back, FLAG_STAGE=2, BYPASS=1:
  - Stimulus: writer A with exe_status=4'b0010, then writer B with 4'b0001.
  - Required: status_cond=4'b0001 while B is in EXE; status sequence 4'b0010 then 4'b0001 on consecutive edges; update_count +2.
- Flush: id_issue=id_s=flush=1 with exe_status=4'hF. Required: no v_exe, status unchanged, update_count unchanged.
- Wrap and mid-flight reset:
  - 256 commits: update_count returns to 0.
  - rst=0 while a writer is in MEM: no commit; status=0.
